uart_rx: RTL and testbench

UART receiver for the SoC's serial port; it is the receive-side counterpart to the transmitter that drives TXD. It deserialises 8N1 frames from the RXD pad into a one-byte holding register with valid, framing-error and overrun flags. The IO block reads these through its memory-mapped read path and acknowledges each byte with a one-cycle read strobe.

---
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Read-side bundle between the UART receiver and the IO block's memory-mapped read path.
// The IO block (master) acknowledges each byte with a one-cycle read_i strobe.
interface uart_rx_if;
    logic       read_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
    logic [2:0] state_dbg;

    modport slave (
        input  read_i,
        output data_o,
        output valid_o,
        output frame_err_o,
        output overrun_o,
        output busy_o,
        output state_dbg
    );

    modport master (
        output read_i,
        input  data_o,
        input  valid_o,
        input  frame_err_o,
        input  overrun_o,
        input  busy_o,
        input  state_dbg
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a one-byte
// holding register with valid, sticky framing-error and sticky overrun flags.
// Read path: the IO block pulses read_i for one cycle to acknowledge the held byte;
// that clears valid_o, overrun_o and frame_err_o at the next edge, except that a
// byte load or framing error in the same cycle takes priority for its own flag.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      rxd_i,
    uart_rx_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_load;
    logic             w_frame_err_set;
    logic             w_busy_nxt;

    // Both synchroniser flops reset high so the line looks idle right after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rxd_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_WAIT_HIGH;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_load          = 1'b0;
        w_frame_err_set = 1'b0;

        case (r_state)
            ST_WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                // Re-check the start bit at its middle; a high line here is a glitch.
                if (r_cnt == CNT_HALF_END) begin
                    if (!r_rx_s) begin
                        w_state_nxt   = ST_DATA;
                        w_cnt_nxt     = '0;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_frame_err_set = 1'b1;
                        w_state_nxt     = ST_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_HIGH;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_START) || (w_state_nxt == ST_DATA) ||
                     (w_state_nxt == ST_STOP);
    end

    // A load beats a simultaneous read for valid/data; a framing error beats it for frame_err.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_load) begin
            r_data      <= r_shift;
            r_valid     <= 1'b1;
            r_overrun   <= !bus.read_i && (r_valid || r_overrun);
            r_frame_err <= !bus.read_i && r_frame_err;
        end else if (w_frame_err_set) begin
            r_frame_err <= 1'b1;
            if (bus.read_i) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end else if (bus.read_i) begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign bus.data_o      = r_data;
    assign bus.valid_o     = r_valid;
    assign bus.frame_err_o = r_frame_err;
    assign bus.overrun_o   = r_overrun;
    assign bus.busy_o      = r_busy;
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: builds a per-cycle stimulus table, derives
// expected outputs from frame timing rules, then replays the table and compares every cycle.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HB   = 8;
  localparam int MAXC = 16384;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  logic rxd;
  always #5 clk = ~clk;

  uart_rx_if bus_if ();

  uart_rx #(
    .CLK_FREQ_HZ(16),
    .BAUD_RATE  (1)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .rxd_i  (rxd),
    .bus    (bus_if)
  );

  // stimulus table, one entry per clock edge
  logic rxd_a [MAXC];
  logic rd_a  [MAXC];
  logic rst_a [MAXC];
  int   n_cyc = 0;

  // reference model products
  logic       rxs_m  [MAXC];
  logic       busy_m [MAXC];
  int         ev_kind[MAXC];
  logic [7:0] ev_byte[MAXC];
  logic [11:0] exp_q[$];

  typedef struct {
    int    t;
    string tag;
    int    sel;
    int    val;
  } dchk_t;
  dchk_t dq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: append cycles to the stimulus table
  task automatic put(input logic line, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_a[n_cyc] = line;
      rd_a[n_cyc]  = 1'b0;
      rst_a[n_cyc] = 1'b0;
      n_cyc++;
    end
  endtask

  task automatic put_read();
    put(1'b1, 1);
    rd_a[n_cyc-1] = 1'b1;
  endtask

  task automatic put_frame(input logic [7:0] b, input logic stop_bit, output int e);
    e = n_cyc;
    put(1'b0, CPB);
    for (int k = 0; k < 8; k++) put(b[k], CPB);
    put(stop_bit, CPB);
  endtask

  task automatic add_chk(input int t, input string tag, input int sel, input int val);
    dchk_t c;
    c.t = t; c.tag = tag; c.sel = sel; c.val = val;
    dq.push_back(c);
  endtask

  task automatic mark_busy(input int from, input int upto);
    for (int i = from; i < upto; i++) busy_m[i] = 1'b1;
  endtask

  // Frame scan over edges [start, lim): waits for a high line, then finds a low edge T,
  // confirms at T+HB, samples bits at T+HB+(k+1)*CPB and the stop bit at T+HB+9*CPB.
  task automatic walk(input int start, input int lim);
    int t;
    int tt;
    int s;
    bit need_high;
    logic [7:0] b;
    t = start;
    need_high = 1'b1;
    while (t < lim) begin
      if (need_high) begin
        if (rxs_m[t]) need_high = 1'b0;
        t++;
      end else if (rxs_m[t]) begin
        t++;
      end else begin
        tt = t;
        if (tt + HB >= lim) begin
          mark_busy(tt, lim);
          t = lim;
        end else if (rxs_m[tt+HB]) begin
          mark_busy(tt, tt + HB);
          t = tt + HB + 1;
        end else begin
          s = tt + HB + 9 * CPB;
          if (s >= lim) begin
            mark_busy(tt, lim);
            t = lim;
          end else begin
            for (int k = 0; k < 8; k++) b[k] = rxs_m[tt + HB + (k + 1) * CPB];
            mark_busy(tt, s);
            if (rxs_m[s]) begin
              ev_kind[s] = 1;
              ev_byte[s] = b;
            end else begin
              ev_kind[s] = 2;
              need_high = 1'b1;
            end
            t = s + 1;
          end
        end
      end
    end
  endtask

  task automatic build_model();
    int seg_start;
    logic [7:0] d;
    logic v, f, o;
    for (int t = 0; t < n_cyc; t++) begin
      busy_m[t]  = 1'b0;
      ev_kind[t] = 0;
      ev_byte[t] = 8'h00;
      if (t < 2) rxs_m[t] = 1'b1;
      else if (rst_a[t-1] || rst_a[t-2]) rxs_m[t] = 1'b1;
      else rxs_m[t] = rxd_a[t-2];
    end
    seg_start = 0;
    for (int t = 0; t < n_cyc; t++) begin
      if (rst_a[t]) begin
        if (seg_start < t) walk(seg_start, t);
        seg_start = t + 1;
      end
    end
    walk(seg_start, n_cyc);
    d = 8'h00; v = 1'b0; f = 1'b0; o = 1'b0;
    for (int t = 0; t < n_cyc; t++) begin
      if (rst_a[t]) begin
        d = 8'h00; v = 1'b0; f = 1'b0; o = 1'b0;
      end else if (ev_kind[t] == 1) begin
        o = rd_a[t] ? 1'b0 : (o | v);
        f = rd_a[t] ? 1'b0 : f;
        d = ev_byte[t];
        v = 1'b1;
      end else if (ev_kind[t] == 2) begin
        f = 1'b1;
        if (rd_a[t]) begin v = 1'b0; o = 1'b0; end
      end else if (rd_a[t]) begin
        v = 1'b0; f = 1'b0; o = 1'b0;
      end
      exp_q.push_back({d, v, f, o, busy_m[t]});
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: obs = 32'(bus_if.data_o);
      1: obs = 32'(bus_if.valid_o);
      2: obs = 32'(bus_if.frame_err_o);
      3: obs = 32'(bus_if.overrun_o);
      default: obs = 32'(bus_if.busy_o);
    endcase
  endfunction

  initial begin
    int e, e2, s, r, g, rand_start;
    logic [11:0] ex;

    // reset and idle line
    put(1'b1, 3);
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;
    add_chk(0, "rst_data", 0, 0);
    add_chk(0, "rst_valid", 1, 0);
    add_chk(0, "rst_busy", 4, 0);
    put(1'b1, 40);

    // clean 0xA5, then read
    put_frame(8'hA5, 1'b1, e);
    s = e + 2 + HB + 9 * CPB;
    add_chk(s - 1, "a5_valid_early", 1, 0);
    add_chk(s, "a5_data", 0, 'hA5);
    add_chk(s, "a5_valid", 1, 1);
    add_chk(s, "a5_ferr", 2, 0);
    add_chk(s, "a5_ovr", 3, 0);
    put(1'b1, 20);
    r = n_cyc;
    put_read();
    add_chk(r, "a5_read_valid", 1, 0);
    add_chk(r, "a5_read_data", 0, 'hA5);
    put(1'b1, 20);

    // 3-cycle glitch on an idle line
    g = n_cyc;
    put(1'b0, 3);
    put(1'b1, 40);
    add_chk(g + 5, "glitch_busy", 4, 1);
    add_chk(g + 12, "glitch_busy_end", 4, 0);
    add_chk(g + 40, "glitch_valid", 1, 0);

    // 0x3C with a low stop bit, line held low, then 0x81
    put_frame(8'h3C, 1'b0, e);
    s = e + 2 + HB + 9 * CPB;
    put(1'b0, 40);
    add_chk(s, "ferr_set", 2, 1);
    add_chk(s, "ferr_valid", 1, 0);
    add_chk(s + 30, "ferr_low_busy", 4, 0);
    put(1'b1, 32);
    put_frame(8'h81, 1'b1, e);
    s = e + 2 + HB + 9 * CPB;
    add_chk(s, "after_ferr_data", 0, 'h81);
    add_chk(s, "after_ferr_valid", 1, 1);
    put(1'b1, 10);
    put_read();
    put(1'b1, 10);

    // back-to-back 0x11, 0x22 with no read -> overrun
    put_frame(8'h11, 1'b1, e);
    put_frame(8'h22, 1'b1, e2);
    s = e2 + 2 + HB + 9 * CPB;
    add_chk(s, "ovr_data", 0, 'h22);
    add_chk(s, "ovr_valid", 1, 1);
    add_chk(s, "ovr_set", 3, 1);
    put(1'b1, 20);
    r = n_cyc;
    put_read();
    add_chk(r, "ovr_read_valid", 1, 0);
    add_chk(r, "ovr_read_ovr", 3, 0);
    put(1'b1, 10);

    // read in the exact load cycle of the second byte
    put_frame(8'h11, 1'b1, e);
    put_frame(8'h22, 1'b1, e2);
    s = e2 + 2 + HB + 9 * CPB;
    rd_a[s] = 1'b1;
    add_chk(s, "rdload_data", 0, 'h22);
    add_chk(s, "rdload_valid", 1, 1);
    add_chk(s, "rdload_ovr", 3, 0);
    put(1'b1, 10);
    put_read();
    put(1'b1, 10);

    // reset inside data bit 4 of 0x5A, then 0x7E after the line settles
    put_frame(8'h5A, 1'b1, e);
    r = e + 5 * CPB + 8;
    rst_a[r] = 1'b1;
    add_chk(r, "midrst_data", 0, 0);
    add_chk(r, "midrst_valid", 1, 0);
    add_chk(r, "midrst_ferr", 2, 0);
    add_chk(r, "midrst_ovr", 3, 0);
    add_chk(r, "midrst_busy", 4, 0);
    put(1'b1, 12 * CPB);
    put_frame(8'h7E, 1'b1, e2);
    s = e2 + 2 + HB + 9 * CPB;
    add_chk(s, "post_rst_data", 0, 'h7E);
    add_chk(s, "post_rst_valid", 1, 1);
    put(1'b1, 20);
    put_read();
    put(1'b1, 20);

    // randomized traffic: bytes, gaps, glitches, bad stops, reads and one reset
    rand_start = n_cyc;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        put(1'b0, $urandom_range(1, 7));
        put(1'b1, $urandom_range(12, 30));
      end
      put_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), e);
      put(1'b1, $urandom_range(0, 30));
    end
    for (int t = rand_start; t < n_cyc; t++) begin
      if ($urandom_range(0, 39) == 0) rd_a[t] = 1'b1;
    end
    rst_a[$urandom_range(rand_start + 200, n_cyc - 1)] = 1'b1;
    put(1'b1, 300);
    put_read();
    put(1'b1, 5);

    build_model();

    // replay: drive on negedge for the next edge, check the previous edge's outputs
    for (int t = 0; t < n_cyc; t++) begin
      rst = rst_a[t];
      rxd = rxd_a[t];
      bus_if.read_i = rd_a[t];
      @(posedge clk);
      @(negedge clk);
      ex = exp_q.pop_front();
      check($sformatf("data@%0d", t),  32'(bus_if.data_o),      32'(ex[11:4]));
      check($sformatf("valid@%0d", t), 32'(bus_if.valid_o),     32'(ex[3]));
      check($sformatf("ferr@%0d", t),  32'(bus_if.frame_err_o), 32'(ex[2]));
      check($sformatf("ovr@%0d", t),   32'(bus_if.overrun_o),   32'(ex[1]));
      check($sformatf("busy@%0d", t),  32'(bus_if.busy_o),      32'(ex[0]));
      foreach (dq[i]) begin
        if (dq[i].t == t) check(dq[i].tag, obs(dq[i].sel), 32'(dq[i].val));
      end
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
